memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the backing store; power of two, at least 16.
REQ-002 Parameter WAIT_CYCLES, default 2: extra response delay in cycles when MEMORY_RESPONDER_WAIT_EN is defined; range 1..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_in  input  Bundle::MemoryIn  request bundle:
- req_valid
- req.addr[31:0]
- req.fcn (M_X/M_XRD/M_XWR)
- req.typ (MT_X/MT_B/MT_H/MT_W/MT_BU/MT_HU)
- req.data[31:0]
REQ-006 mem_out  output  Bundle::MemoryOut  response bundle: res_valid, res.data[31:0].
REQ-007 busy  output  1  high while a request is in flight and no new request is accepted; drives the core's cmiss_stall.
REQ-008 misaligned  output  1  one-cycle pulse, coincident with res_valid, flagging a misaligned access.

Function
REQ-009 A request is accepted on a rising edge where req_valid=1 and busy=0; with busy=1, req_valid is ignored.
REQ-010 Word index is req.addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-011 Misalignment conditions:
- MT_H/MT_HU with addr[0]=1
- MT_W with addr[1:0]!=0
REQ-012 A misaligned access leaves the store unchanged, returns res.data=0 and pulses misaligned.
REQ-013 Aligned write (fcn=M_XWR) write-enables these lanes on the acceptance edge:
- MT_B/MT_BU: byte lane addr[1:0]
- MT_H/MT_HU: lanes {addr[1],0} and {addr[1],1}
- MT_W/MT_X: all four lanes
REQ-014 Write data for a lane is always taken from the low bits of req.data, so byte writes use req.data[7:0] and halfword writes use req.data[15:0].
REQ-015 Aligned read (fcn=M_XRD) latches the word, addr[1:0] and typ at acceptance.
REQ-016 Read data is shifted right by 8*addr[1:0], then extended:
- MT_B: sign-extend from bit 7
- MT_BU: zero-extend from bit 7
- MT_H: sign-extend from bit 15
- MT_HU: zero-extend from bit 15
- MT_W/MT_X: unchanged
REQ-017 Writes and fcn=M_X also produce a response, with res.data=0.
REQ-018 States and transitions:
- IDLE -> RESPOND on acceptance (macro undefined)
- IDLE -> WAIT on acceptance (macro defined)
- WAIT -> RESPOND when the wait counter reaches 0
- RESPOND -> IDLE unconditionally
REQ-019 res_valid is high exactly one cycle, in RESPOND; res.data and misaligned are valid only then; res.data=0 outside RESPOND.
REQ-020 busy is high in WAIT, and low in IDLE and RESPOND.
REQ-021 Because busy is low in RESPOND, a request presented in RESPOND is accepted, which allows back-to-back accesses.
REQ-022 A read following a write to the same word returns the updated data (write committed at its acceptance edge).
REQ-023 Backing-store contents are not initialized by reset; power-up contents are undefined.

Reset
REQ-024 While reset=1 the FSM is forced to IDLE and the wait counter to 0.
REQ-025 While reset=1 all outputs are 0: res_valid=0, res.data=0, busy=0, misaligned=0.
REQ-026 Reset asserted in WAIT or RESPOND discards the pending response, which is never delivered.
REQ-027 A write already committed before reset remains in the store.
REQ-028 The first acceptance is possible on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MEMORY_RESPONDER_WAIT_EN controls the wait-state path.
REQ-030 With MEMORY_RESPONDER_WAIT_EN undefined:
- no WAIT state and no counter
- busy tied to 0
- fixed latency: res_valid one cycle after acceptance
REQ-031 With MEMORY_RESPONDER_WAIT_EN defined:
- the counter loads WAIT_CYCLES-1 on acceptance
- busy stays high for WAIT_CYCLES cycles
- res_valid arrives WAIT_CYCLES+1 cycles after acceptance

Verification
REQ-032 Write W addr=0x10 data=0xDEADBEEF, then read W addr=0x10 -> res.data=0xDEADBEEF, misaligned=0.
REQ-033 After REQ-032, read MT_B addr=0x13 -> 0xFFFFFFDE; read MT_BU addr=0x13 -> 0x000000DE; read MT_HU addr=0x12 -> 0x0000DEAD.
REQ-034 Write MT_B addr=0x11 data=0x12345677, then read W addr=0x10 -> 0xDEAD77EF.
REQ-035 Read MT_W addr=0x12 -> misaligned=1, res.data=0, store unchanged on re-read.
REQ-036 Macro defined, WAIT_CYCLES=2, read requests issued every cycle:
- busy=1 for 2 cycles
- res_valid at acceptance+3
- req_valid while busy is ignored
REQ-037 Reset asserted in WAIT -> no res_valid afterwards; outputs 0; a new read after release returns the correct data.

Source files
------------

// File: rtl/memory_responder.sv
// memory_responder: word-organised backing store answering one load/store at a time.
// Define MEMORY_RESPONDER_WAIT_EN to insert WAIT_CYCLES wait states (with busy) before each response.
package Bundle;
    localparam logic [1:0] M_X = 2'd0, M_XRD = 2'd1, M_XWR = 2'd2;
    localparam logic [2:0] MT_X = 3'd0, MT_B = 3'd1, MT_H = 3'd2, MT_W = 3'd3, MT_BU = 3'd4, MT_HU = 3'd5;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  fcn;
        logic [2:0]  typ;
        logic [31:0] data;
    } MemReq;
    typedef struct packed {
        logic  req_valid;
        MemReq req;
    } MemoryIn;
    typedef struct packed {
        logic [31:0] data;
    } MemResp;
    typedef struct packed {
        logic   res_valid;
        MemResp res;
    } MemoryOut;
endpackage

module memory_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  Bundle::MemoryIn  mem_in,
    output Bundle::MemoryOut mem_out,
    output logic             busy,
    output logic             misaligned
);
    import Bundle::*;
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_data;
    logic          r_mis;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [2:0]    w_typ;
    logic          w_byte, w_half, w_mis, w_accept, w_resp, w_unused;
    logic [31:0]   w_shift, w_rdata, w_wdata;
    logic [3:0]    w_be;

`ifdef MEMORY_RESPONDER_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;
    localparam state_t S_ACCEPT = S_WAIT;
    logic [3:0] r_cnt;
`else
    typedef enum logic {S_IDLE, S_RESPOND} state_t;
    localparam state_t S_ACCEPT = S_RESPOND;
`endif
    state_t r_state;

    assign w_idx    = mem_in.req.addr[AW+1:2];
    assign w_off    = mem_in.req.addr[1:0];
    assign w_typ    = mem_in.req.typ;
    assign w_byte   = w_typ == MT_B || w_typ == MT_BU;
    assign w_half   = w_typ == MT_H || w_typ == MT_HU;
    assign w_mis    = mem_in.req.fcn != M_X && ((w_half && w_off[0]) || (w_typ == MT_W && w_off != 2'd0));
    assign w_unused = ^{mem_in.req.addr[31:AW+2], 4'(WAIT_CYCLES)};

    // Lanes always take their data from the low bits of req.data, replicated across the word
    assign w_wdata = w_byte ? {4{mem_in.req.data[7:0]}} : w_half ? {2{mem_in.req.data[15:0]}} : mem_in.req.data;
    assign w_be    = w_byte ? 4'b0001 << w_off : w_half ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign w_shift = r_mem[w_idx] >> {w_off, 3'b000};
    assign w_rdata = w_typ == MT_B  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     w_typ == MT_BU ? {24'd0, w_shift[7:0]} :
                     w_typ == MT_H  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                     w_typ == MT_HU ? {16'd0, w_shift[15:0]} : w_shift;

`ifdef MEMORY_RESPONDER_WAIT_EN
    assign busy = r_state == S_WAIT;
`else
    assign busy = 1'b0;
`endif
    assign w_accept   = mem_in.req_valid && !busy;
    assign w_resp     = r_state == S_RESPOND;
    assign mem_out    = {w_resp, w_resp ? r_data : 32'd0};
    assign misaligned = w_resp && r_mis;

    // Store is deliberately left out of reset so it survives a reset pulse
    always_ff @(posedge clk)
        if (w_accept && !w_mis && mem_in.req.fcn == M_XWR)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_mis   <= 1'b0;
`ifdef MEMORY_RESPONDER_WAIT_EN
            r_cnt   <= '0;
        end else if (r_state == S_WAIT) begin
            if (r_cnt == 4'd0) r_state <= S_RESPOND;
            else r_cnt <= r_cnt - 4'd1;
`endif
        end else if (w_accept) begin
            r_state <= S_ACCEPT;
            r_data  <= mem_in.req.fcn == M_XRD && !w_mis ? w_rdata : 32'd0;
            r_mis   <= w_mis;
`ifdef MEMORY_RESPONDER_WAIT_EN
            r_cnt   <= 4'(WAIT_CYCLES - 1);
`endif
        end else begin
            r_state <= S_IDLE;
        end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed load/store vectors checked every cycle against a byte-level reference model.
module tb_memory_responder;
    import Bundle::*;
    localparam int DW = 16;
    localparam int WC = 2;
`ifdef MEMORY_RESPONDER_WAIT_EN
    localparam int LAT = WC + 1;
    localparam int BUSY_N = WC;
`else
    localparam int LAT = 1;
    localparam int BUSY_N = 0;
`endif

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          mis;
        bit          hl;
        logic [31:0] lit;
    } resp_t;

    logic     clk = 0;
    logic     reset = 0;
    MemoryIn  mem_in = '0;
    MemoryOut mem_out;
    logic     busy, misaligned;

    resp_t       q[$];
    logic [7:0]  mb[int];
    int          cyc = 0, busy_until = -1, n_tests = 0, n_fail = 0;
    logic        exp_valid = 0, exp_mis = 0, exp_busy = 0, exp_hl = 0;
    logic [31:0] exp_data = 0, exp_lit = 0;

    memory_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .mem_in(mem_in), .mem_out(mem_out), .busy(busy), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("res_valid", 32'(mem_out.res_valid), 32'(exp_valid));
        chk("res_data", mem_out.res.data, exp_data);
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (exp_valid && exp_hl) chk("model_literal", exp_data, exp_lit);
    end

    // Reference: byte-addressed little-endian store, addresses wrap at 4*DW bytes
    task automatic model_accept(input logic [1:0] f, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] d, input bit hl, input logic [31:0] lit);
        int ba, wb, off, n, base;
        bit is_b, is_h, mis;
        logic [31:0] w, val;
        ba   = int'(a % (4 * DW));
        off  = ba % 4;
        wb   = ba - off;
        is_b = t == MT_B || t == MT_BU;
        is_h = t == MT_H || t == MT_HU;
        mis  = f != M_X && ((is_h && off % 2 == 1) || (t == MT_W && off != 0));
        val  = 0;
        if (f == M_XWR && !mis) begin
            n    = is_b ? 1 : is_h ? 2 : 4;
            base = n == 4 ? wb : ba;
            for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
        end
        if (f == M_XRD && !mis) begin
            w = {mb[wb + 3], mb[wb + 2], mb[wb + 1], mb[wb]} >> (8 * off);
            if (t == MT_B) val = w[7] ? (w & 32'hFF) | 32'hFFFFFF00 : w & 32'hFF;
            else if (t == MT_BU) val = w & 32'hFF;
            else if (t == MT_H) val = w[15] ? (w & 32'hFFFF) | 32'hFFFF0000 : w & 32'hFFFF;
            else if (t == MT_HU) val = w & 32'hFFFF;
            else val = w;
        end
        q.push_back('{due: cyc + LAT - 1, data: val, mis: mis, hl: hl, lit: lit});
        busy_until = cyc + BUSY_N - 1;
    endtask

    task automatic step(input bit v, input logic [1:0] f, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input bit hl, input logic [31:0] lit);
        resp_t r;
        mem_in.req_valid = v;
        mem_in.req.fcn   = f;
        mem_in.req.typ   = t;
        mem_in.req.addr  = a;
        mem_in.req.data  = d;
        @(posedge clk);
        cyc++;
        if (!reset && v && busy_until < cyc - 1) model_accept(f, t, a, d, hl, lit);
        #1;
        {exp_valid, exp_mis, exp_hl, exp_data, exp_lit} = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r         = q.pop_front();
            exp_valid = 1;
            exp_data  = r.data;
            exp_mis   = r.mis;
            exp_hl    = r.hl;
            exp_lit   = r.lit;
        end
        exp_busy = busy_until >= cyc;
        mem_in.req_valid = 0;
    endtask

    task automatic idle();
        step(0, M_X, MT_X, 0, 0, 0, 0);
    endtask

    task automatic req(input logic [1:0] f, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input bit hl, input logic [31:0] lit);
        step(1, f, t, a, d, hl, lit);
        repeat (BUSY_N) idle();
    endtask

    task automatic rd(input logic [2:0] t, input logic [31:0] a, input logic [31:0] lit);
        req(M_XRD, t, a, 0, 1, lit);
    endtask

    task automatic wr(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        req(M_XWR, t, a, d, 1, 0);
    endtask

    task automatic rst_pulse(input int n);
        reset = 1;
        q.delete();
        busy_until = -1;
        {exp_valid, exp_mis, exp_busy, exp_hl, exp_data, exp_lit} = '0;
        repeat (n) idle();
        reset = 0;
    endtask

    initial begin
        #1 reset = 1;
        repeat (3) idle();
        reset = 0;
        wr(MT_W, 32'h10, 32'hDEADBEEF);
        rd(MT_W, 32'h10, 32'hDEADBEEF);
        rd(MT_B, 32'h13, 32'hFFFFFFDE);
        rd(MT_BU, 32'h13, 32'h000000DE);
        rd(MT_HU, 32'h12, 32'h0000DEAD);
        rd(MT_H, 32'h12, 32'hFFFFDEAD);
        rd(MT_H, 32'h10, 32'hFFFFBEEF);
        rd(MT_B, 32'h10, 32'hFFFFFFEF);
        wr(MT_B, 32'h11, 32'h12345677);
        rd(MT_W, 32'h10, 32'hDEAD77EF);
        rd(MT_W, 32'h12, 32'h0);
        rd(MT_W, 32'h10, 32'hDEAD77EF);
        wr(MT_H, 32'h12, 32'hAAAA5555);
        rd(MT_W, 32'h10, 32'h555577EF);
        wr(MT_W, 32'h13, 32'hFFFFFFFF);
        wr(MT_H, 32'h11, 32'hFFFFFFFF);
        rd(MT_HU, 32'h11, 32'h0);
        rd(MT_W, 32'h10, 32'h555577EF);
        idle();
        wr(MT_W, 32'h50, 32'h0BADF00D);
        rd(MT_W, 32'h10, 32'h0BADF00D);
        wr(MT_W, 32'h3C, 32'h80000001);
        rd(MT_W, 32'h7C, 32'h80000001);
        rd(MT_BU, 32'h3F, 32'h00000080);
        req(M_X, MT_W, 32'h10, 32'h12345678, 1, 32'h0);
        for (int i = 0; i < 8; i++) step(1, M_XRD, MT_B, 32'h10 + 32'(i % 4), 0, 0, 0);
        repeat (LAT + 1) idle();
        step(1, M_XRD, MT_W, 32'h10, 0, 1, 32'h0BADF00D);
        rst_pulse(2);
        repeat (LAT + 1) idle();
        rd(MT_W, 32'h10, 32'h0BADF00D);
        rd(MT_W, 32'h3C, 32'h80000001);
        repeat (LAT + 1) idle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
